// File: rtl/proj_enemy_collision_scan.sv
// Projectile-vs-enemy-grid collision scanner: snapshots positions on start and walks live (proj,enemy) pairs one per cycle.
// Optional COLLISION_HIT_COUNT_EN adds a saturating o_hitCount output.
module proj_enemy_collision_scan #(
  parameter int unsigned ENEMY_ROWS = 2,
  parameter int unsigned ENEMY_COLS = 4,
  parameter int unsigned SPACING_X  = 40,
  parameter int unsigned SPACING_Y  = 30,
  parameter int unsigned ENEMY_W    = 20,
  parameter int unsigned ENEMY_H    = 16,
  parameter int unsigned PROJ_W     = 4,
  parameter int unsigned PROJ_H     = 8
) (
  input  logic                                     i_clk,
  input  logic                                     i_rst,
  input  logic                                     i_start,
  input  logic [9:0]                               i_proj1X,
  input  logic [9:0]                               i_proj2X,
  input  logic [9:0]                               i_proj3X,
  input  logic [8:0]                               i_proj1Y,
  input  logic [8:0]                               i_proj2Y,
  input  logic [8:0]                               i_proj3Y,
  input  logic [9:0]                               i_gridX,
  input  logic [8:0]                               i_gridY,
  input  logic [ENEMY_ROWS*ENEMY_COLS-1:0]         i_aliveMask,
  output logic                                     o_busy,
  output logic                                     o_projHit,
  output logic [1:0]                               o_collidedProj,
  output logic [$clog2(ENEMY_ROWS*ENEMY_COLS)-1:0] o_enemyIdx,
  output logic                                     o_done
`ifdef COLLISION_HIT_COUNT_EN
  ,
  output logic [7:0]                               o_hitCount
`endif
);
  localparam int unsigned N  = ENEMY_ROWS * ENEMY_COLS;
  localparam int unsigned IW = $clog2(N);

  typedef enum logic [2:0] {S_IDLE, S_LOAD, S_SCAN, S_HIT, S_DONE} state_t;
  state_t r_state, w_state_nxt;

  logic [1:0]       r_p, w_p_nxt;
  logic [IW-1:0]    r_e, w_e_nxt;
  logic [2:0][9:0]  r_px;
  logic [2:0][8:0]  r_py;
  logic [9:0]       r_gx;
  logic [8:0]       r_gy;
  logic [N-1:0]     r_alive, w_alive_eff;

  logic             r_busy, r_hit, r_done;
  logic [1:0]       r_cp;
  logic [IW-1:0]    r_idx;
  logic             w_busy_d, w_hit_d, w_done_d;
  logic [1:0]       w_cp_d;
  logic [IW-1:0]    w_idx_d;

  logic             w_active, w_adv_ok, w_c_ok, w_c_hit;
  logic [1:0]       w_adv_p, w_c_p;
  logic [IW-1:0]    w_c_e;
  int unsigned      w_col, w_row;
  logic [10:0]      w_px, w_py, w_ex, w_ey;

  assign w_active = (r_state == S_LOAD) || (r_state == S_SCAN) || (r_state == S_HIT);

  // The enemy just hit is already gone for the pair examined in the same cycle.
  assign w_alive_eff = (r_state == S_HIT) ? (r_alive & ~(N'(1) << r_e)) : r_alive;

  // Lowest active projectile above r_p; inactive ones cost no cycles.
  always_comb begin
    w_adv_ok = 1'b0;
    w_adv_p  = 2'd0;
    for (int k = 3; k >= 1; k--) begin
      if (2'(k) > r_p && r_py[k-1] != 9'd0) begin
        w_adv_ok = 1'b1;
        w_adv_p  = 2'(k);
      end
    end
  end

  // Pair visited next cycle; its overlap is resolved now so the hit pulse is registered.
  always_comb begin
    w_c_ok = 1'b0;
    w_c_p  = r_p;
    w_c_e  = '0;
    if (r_state == S_SCAN && r_e != IW'(N-1)) begin
      w_c_ok = 1'b1;
      w_c_e  = r_e + 1'b1;
    end else if (w_adv_ok) begin
      w_c_ok = 1'b1;
      w_c_p  = w_adv_p;
    end
  end

  always_comb begin
    case (w_c_p)
      2'd2:    begin w_px = {1'b0, r_px[1]}; w_py = {2'b0, r_py[1]}; end
      2'd3:    begin w_px = {1'b0, r_px[2]}; w_py = {2'b0, r_py[2]}; end
      default: begin w_px = {1'b0, r_px[0]}; w_py = {2'b0, r_py[0]}; end
    endcase
    w_col   = 32'(w_c_e) % ENEMY_COLS;
    w_row   = 32'(w_c_e) / ENEMY_COLS;
    w_ex    = 11'(r_gx) + 11'(w_col * SPACING_X);
    w_ey    = 11'(r_gy) + 11'(w_row * SPACING_Y);
    w_c_hit = w_c_ok && w_alive_eff[w_c_e] &&
              (w_px < w_ex + 11'(ENEMY_W)) && (w_px + 11'(PROJ_W) > w_ex) &&
              (w_py < w_ey + 11'(ENEMY_H)) && (w_py + 11'(PROJ_H) > w_ey);
  end

  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      S_IDLE:                 if (i_start) w_state_nxt = S_LOAD;
      S_LOAD, S_SCAN, S_HIT:  w_state_nxt = !w_c_ok ? S_DONE : (w_c_hit ? S_HIT : S_SCAN);
      S_DONE:                 w_state_nxt = S_IDLE;
      default:                w_state_nxt = S_IDLE;
    endcase
  end

  always_comb begin
    w_p_nxt  = (w_active && w_c_ok) ? w_c_p : 2'd0;
    w_e_nxt  = (w_active && w_c_ok) ? w_c_e : '0;
    w_busy_d = (w_state_nxt != S_IDLE);
    w_hit_d  = (w_state_nxt == S_HIT);
    w_done_d = (w_state_nxt == S_DONE);
    w_cp_d   = w_hit_d ? w_c_p : 2'd0;
    w_idx_d  = w_hit_d ? w_c_e : '0;
  end

  always_ff @(posedge i_clk) begin
    if (!i_rst) begin
      r_state <= S_IDLE;
      r_p     <= 2'd0;
      r_e     <= '0;
      r_px    <= '0;
      r_py    <= '0;
      r_gx    <= '0;
      r_gy    <= '0;
      r_alive <= '0;
      r_busy  <= 1'b0;
      r_hit   <= 1'b0;
      r_done  <= 1'b0;
      r_cp    <= 2'd0;
      r_idx   <= '0;
    end else begin
      r_state <= w_state_nxt;
      r_p     <= w_p_nxt;
      r_e     <= w_e_nxt;
      r_busy  <= w_busy_d;
      r_hit   <= w_hit_d;
      r_done  <= w_done_d;
      r_cp    <= w_cp_d;
      r_idx   <= w_idx_d;
      if (r_state == S_IDLE && i_start) begin
        r_px    <= {i_proj3X, i_proj2X, i_proj1X};
        r_py    <= {i_proj3Y, i_proj2Y, i_proj1Y};
        r_gx    <= i_gridX;
        r_gy    <= i_gridY;
        r_alive <= i_aliveMask;
      end else if (r_state == S_HIT) begin
        r_alive <= w_alive_eff;
      end
    end
  end

  assign o_busy         = r_busy;
  assign o_projHit      = r_hit;
  assign o_collidedProj = r_cp;
  assign o_enemyIdx     = r_idx;
  assign o_done         = r_done;

`ifdef COLLISION_HIT_COUNT_EN
  logic [7:0] r_hitCount;
  always_ff @(posedge i_clk) begin
    if (!i_rst)                                      r_hitCount <= 8'd0;
    else if (r_state == S_HIT && r_hitCount != 8'hFF) r_hitCount <= r_hitCount + 8'd1;
  end
  assign o_hitCount = r_hitCount;
`endif
endmodule

// File: tb/tb_proj_enemy_collision_scan.sv
// Bench for proj_enemy_collision_scan: directed corner cases plus random scans against a pair-walk reference model.
module tb_proj_enemy_collision_scan;
  localparam int N = 8;
  localparam int COLS = 4;

  logic       clk = 1'b0;
  logic       rst, start;
  logic [9:0] p1x, p2x, p3x, gx;
  logic [8:0] p1y, p2y, p3y, gy;
  logic [7:0] alive;
  logic       busy, projHit, done;
  logic [1:0] cproj;
  logic [2:0] eidx;
`ifdef COLLISION_HIT_COUNT_EN
  logic [7:0] hitCount;
`endif

  int n_chk = 0;
  int n_err = 0;
  int q_p[$], q_e[$], q_k[$];

  proj_enemy_collision_scan dut (
    .i_clk(clk), .i_rst(rst), .i_start(start),
    .i_proj1X(p1x), .i_proj2X(p2x), .i_proj3X(p3x),
    .i_proj1Y(p1y), .i_proj2Y(p2y), .i_proj3Y(p3y),
    .i_gridX(gx), .i_gridY(gy), .i_aliveMask(alive),
    .o_busy(busy), .o_projHit(projHit), .o_collidedProj(cproj),
    .o_enemyIdx(eidx), .o_done(done)
`ifdef COLLISION_HIT_COUNT_EN
    , .o_hitCount(hitCount)
`endif
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input int got, input int exp);
    n_chk++;
    if (got != exp) begin
      n_err++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  // Walk projectiles in order; first live overlapping enemy wins and is consumed.
  task automatic model(output int exp_done);
    int px[3], py[3];
    logic [7:0] al;
    int cyc, ex, ey, hit_e;
    px[0] = int'(p1x); px[1] = int'(p2x); px[2] = int'(p3x);
    py[0] = int'(p1y); py[1] = int'(p2y); py[2] = int'(p3y);
    al = alive;
    q_p.delete(); q_e.delete(); q_k.delete();
    cyc = 2;
    for (int p = 0; p < 3; p++) begin
      if (py[p] != 0) begin
        hit_e = -1;
        for (int e = 0; e < N; e++) begin
          ex = int'(gx) + (e % COLS) * 40;
          ey = int'(gy) + (e / COLS) * 30;
          if (al[e] && px[p] < ex + 20 && px[p] + 4 > ex && py[p] < ey + 16 && py[p] + 8 > ey) begin
            hit_e = e;
            break;
          end
        end
        if (hit_e >= 0) begin
          q_p.push_back(p + 1); q_e.push_back(hit_e); q_k.push_back(cyc + hit_e);
          al[hit_e] = 1'b0;
          cyc += hit_e + 1;
        end else begin
          cyc += N;
        end
      end
    end
    exp_done = cyc;
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst = 1'b0; start = 1'b0;
    repeat (2) @(negedge clk);
    rst = 1'b1;
  endtask

  task automatic run_scan(input string tag, input bit scramble);
    int exp_done, done_k, extra, stray, bad_busy;
    model(exp_done);
    done_k = -1; extra = 0; stray = 0; bad_busy = 0;
    @(negedge clk);
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    for (int k = 1; k <= 100; k++) begin
      if (k > 1) @(negedge clk);
      if (scramble && k == 2) begin
        p1x = 10'($urandom); p2y = 9'($urandom); gx = 10'($urandom); alive = 8'($urandom);
      end
      if (!busy) bad_busy++;
      if (projHit) begin
        if (q_p.size() > 0) begin
          chk({tag, "_proj"}, int'(cproj), q_p.pop_front());
          chk({tag, "_idx"},  int'(eidx),  q_e.pop_front());
          chk({tag, "_hitk"}, k,           q_k.pop_front());
        end else extra++;
      end else if (cproj != 2'd0 || eidx != 3'd0) stray++;
      if (done) begin done_k = k; break; end
    end
    chk({tag, "_done_k"},  done_k, exp_done);
    chk({tag, "_missing"}, q_p.size(), 0);
    chk({tag, "_extra"},   extra, 0);
    chk({tag, "_stray"},   stray, 0);
    chk({tag, "_busy"},    bad_busy, 0);
    @(negedge clk);
    chk({tag, "_idle"}, int'({busy, done, projHit}), 0);
  endtask

  task automatic base_cfg();
    gx = 10'd100; gy = 9'd50; alive = 8'hFF;
    p1x = 10'd142; p1y = 9'd60;
    p2x = 10'd0;   p2y = 9'd0;
    p3x = 10'd0;   p3y = 9'd0;
  endtask

  int t;
  int hits, dones, dbl;

  initial begin
    rst = 1'b0; start = 1'b0;
    base_cfg();
    repeat (3) @(negedge clk);
    chk("rst_busy", int'(busy), 0);
    chk("rst_out", int'({projHit, cproj, eidx, done}), 0);
    rst = 1'b1;

    base_cfg();
    run_scan("single_hit", 1'b0);

    base_cfg(); p2x = 10'd144; p2y = 9'd62;
    run_scan("consumed", 1'b0);

    base_cfg(); p1x = 10'd160;
    run_scan("edge_touch", 1'b0);
    base_cfg(); p1x = 10'd159;
    run_scan("edge_in", 1'b0);

    base_cfg(); alive = 8'h00;
    p2x = 10'd180; p2y = 9'd85; p3x = 10'd222; p3y = 9'd52;
    run_scan("dead_grid", 1'b0);

    base_cfg(); p1y = 9'd0;
    run_scan("all_inactive", 1'b0);

    // reset pulse in the middle of a long scan
    base_cfg(); alive = 8'h00; p2y = 9'd70; p3y = 9'd90;
    @(negedge clk); start = 1'b1;
    @(negedge clk); start = 1'b0;
    repeat (5) @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    rst = 1'b1;
    chk("midrst_out", int'({busy, projHit, done}), 0);
    hits = 0; dones = 0;
    repeat (40) begin
      @(negedge clk);
      if (projHit) hits++;
      if (done || busy) dones++;
    end
    chk("midrst_quiet", hits + dones, 0);
    run_scan("after_rst", 1'b0);

    // start held high: one 5-cycle scan per IDLE entry
    base_cfg();
    hits = 0; dones = 0; dbl = 0;
    @(negedge clk); start = 1'b1;
    for (int k = 0; k < 30; k++) begin
      @(negedge clk);
      if (done && k > 0 && t == 1) dbl++;
      t = int'(done);
      if (projHit) hits++;
      if (done) dones++;
    end
    start = 1'b0;
    repeat (8) @(negedge clk);
    chk("held_dones", dones, 6);
    chk("held_hits", hits, 6);
    chk("held_double", dbl, 0);
    chk("held_idle", int'(busy), 0);

    // random scans near the grid, inputs scrambled after the snapshot
    for (int r = 0; r < 25; r++) begin
      gx = 10'($urandom_range(0, 860));
      gy = 9'($urandom_range(1, 440));
      alive = 8'($urandom);
      for (int p = 0; p < 3; p++) begin
        int x, y;
        x = int'(gx) + int'($urandom_range(0, 175)) - 10;
        y = int'(gy) + int'($urandom_range(0, 60)) - 10;
        if (x < 0) x = 0;
        if (x > 1023) x = 1023;
        if (y < 1) y = 1;
        if (y > 511) y = 511;
        if ($urandom_range(0, 3) == 0) y = 0;
        case (p)
          0: begin p1x = 10'(x); p1y = 9'(y); end
          1: begin p2x = 10'(x); p2y = 9'(y); end
          default: begin p3x = 10'(x); p3y = 9'(y); end
        endcase
      end
      run_scan($sformatf("rnd%0d", r), 1'b1);
    end

`ifdef COLLISION_HIT_COUNT_EN
    do_reset();
    @(negedge clk);
    chk("hcnt0", int'(hitCount), 0);
    base_cfg();
    run_scan("hcnt_a", 1'b0);
    chk("hcnt1", int'(hitCount), 1);
    base_cfg();
    run_scan("hcnt_b", 1'b0);
    chk("hcnt2", int'(hitCount), 2);
`endif

    $display("Simulation finished: %0d checks, %0d errors", n_chk, n_err);
    $finish;
  end
endmodule
